alu_cmd_sequencer: RTL and testbench

- Requestor-side driver for the 16-bit combinational ALU (`alu_module`: a, b, alu_code → c, overflow).
- Accepts operation commands over a valid/ready handshake and validates the opcode.
- Holds registered operands on the ALU for a programmable settle time, then captures c/overflow and returns the result over a second valid/ready handshake.
- Supports accumulator chaining (previous result as operand a) and a saturating overflow statistic.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_code_check.sv | 11 +
 rtl/alu_module.sv | 48 ++++
 rtl/alu_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, sequencer state encoding and opcode legality helper
package alu_pkg;

    localparam int ALU_CODE_W = 5;

    localparam logic [ALU_CODE_W-1:0] ADD_S = 5'b00000;
    localparam logic [ALU_CODE_W-1:0] ADD_U = 5'b00001;
    localparam logic [ALU_CODE_W-1:0] SUB_S = 5'b00010;
    localparam logic [ALU_CODE_W-1:0] SUB_U = 5'b00011;
    localparam logic [ALU_CODE_W-1:0] INC   = 5'b00100;
    localparam logic [ALU_CODE_W-1:0] DEC   = 5'b00101;

    localparam logic [ALU_CODE_W-1:0] LAND  = 5'b01000;
    localparam logic [ALU_CODE_W-1:0] LOR   = 5'b01001;
    localparam logic [ALU_CODE_W-1:0] LXOR  = 5'b01010;
    localparam logic [ALU_CODE_W-1:0] LNOT  = 5'b01011;
    localparam logic [ALU_CODE_W-1:0] LNAND = 5'b01100;
    localparam logic [ALU_CODE_W-1:0] LNOR  = 5'b01101;

    localparam logic [ALU_CODE_W-1:0] SLL   = 5'b10000;
    localparam logic [ALU_CODE_W-1:0] SRL   = 5'b10001;
    localparam logic [ALU_CODE_W-1:0] SLA   = 5'b10010;
    localparam logic [ALU_CODE_W-1:0] SRA   = 5'b10011;

    localparam logic [ALU_CODE_W-1:0] SLE   = 5'b11000;
    localparam logic [ALU_CODE_W-1:0] SLT   = 5'b11001;
    localparam logic [ALU_CODE_W-1:0] SGE   = 5'b11010;
    localparam logic [ALU_CODE_W-1:0] SGT   = 5'b11011;
    localparam logic [ALU_CODE_W-1:0] SEQ   = 5'b11100;
    localparam logic [ALU_CODE_W-1:0] SNE   = 5'b11101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    // Each opcode group occupies the low end of its 8-code block.
    function automatic logic is_legal_code(input logic [ALU_CODE_W-1:0] code);
        logic w_ok;
        case (code[4:3])
            2'b10:   w_ok = (code[2:0] <= 3'd3);
            default: w_ok = (code[2:0] <= 3'd5);
        endcase
        return w_ok;
    endfunction

endpackage

// File: rtl/alu_code_check.sv
// rtl/alu_code_check.sv - combinational ALU opcode legality decoder
module alu_code_check
    import alu_pkg::*;
(
    input  logic [ALU_CODE_W-1:0] i_code,
    output logic                  o_legal
);

    assign o_legal = is_legal_code(i_code);

endmodule

// File: rtl/alu_module.sv
// rtl/alu_module.sv - 16-bit combinational ALU driven by the command sequencer
module alu_module
    import alu_pkg::*;
(
    input  logic [15:0]           a,
    input  logic [15:0]           b,
    input  logic [ALU_CODE_W-1:0] alu_code,
    output logic [15:0]           c,
    output logic                  overflow
);

    logic [16:0] w_sum;
    logic [16:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        c        = '0;
        overflow = 1'b0;
        case (alu_code)
            ADD_S: begin c = w_sum[15:0];  overflow = (a[15] == b[15]) && (w_sum[15] != a[15]); end
            ADD_U: begin c = w_sum[15:0];  overflow = w_sum[16]; end
            SUB_S: begin c = w_diff[15:0]; overflow = (a[15] != b[15]) && (w_diff[15] != a[15]); end
            SUB_U: begin c = w_diff[15:0]; overflow = w_diff[16]; end
            INC:   begin c = a + 16'd1;    overflow = (a == 16'h7FFF); end
            DEC:   begin c = a - 16'd1;    overflow = (a == 16'h8000); end
            LAND:  c = a & b;
            LOR:   c = a | b;
            LXOR:  c = a ^ b;
            LNOT:  c = ~a;
            LNAND: c = ~(a & b);
            LNOR:  c = ~(a | b);
            SLL:   c = a << 1;
            SRL:   c = a >> 1;
            SLA:   begin c = a << 1; overflow = (a[15] != a[14]); end
            SRA:   c = $unsigned($signed(a) >>> 1);
            SLE:   c = {15'd0, $signed(a) <= $signed(b)};
            SLT:   c = {15'd0, $signed(a) <  $signed(b)};
            SGE:   c = {15'd0, $signed(a) >= $signed(b)};
            SGT:   c = {15'd0, $signed(a) >  $signed(b)};
            SEQ:   c = {15'd0, a == b};
            SNE:   c = {15'd0, a != b};
            default: begin c = '0; overflow = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - drives the external ALU from a command stream and returns captured results
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int CODE_W        = 5,
    parameter int SETTLE_CYCLES = 2,
    parameter int OVF_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic [CODE_W-1:0]    cmd_code,
    input  logic                 cmd_use_prev,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [CODE_W-1:0]    alu_code,
    input  logic [WIDTH-1:0]     alu_c,
    input  logic                 alu_overflow,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_c,
    output logic                 res_overflow,
    output logic                 res_err,
    input  logic                 stat_clr,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    seq_state_t           r_state;
    seq_state_t           w_next_state;
    logic [3:0]           r_settle_cnt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic [CODE_W-1:0]    r_alu_code;
    logic [WIDTH-1:0]     r_res_c;
    logic                 r_res_overflow;
    logic                 r_res_err;
    logic [OVF_CNT_W-1:0] r_ovf_count;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_capture;

    alu_code_check u_code_check (
        .i_code  (cmd_code),
        .o_legal (w_legal)
    );

    assign w_accept  = (r_state == IDLE) && cmd_valid;
    assign w_capture = (r_state == WAIT) && (r_settle_cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_next_state = w_legal ? WAIT : HOLD;
            WAIT:    if (r_settle_cnt == 4'd0) w_next_state = HOLD;
            HOLD:    if (res_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        res_valid = (r_state == HOLD);
    end

    // ALU inputs only change on a legal accept, so they stay frozen through WAIT and HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_code     <= '0;
            r_settle_cnt   <= '0;
            r_acc          <= '0;
            r_res_c        <= '0;
            r_res_overflow <= 1'b0;
            r_res_err      <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) begin
                r_alu_a      <= cmd_use_prev ? r_acc : cmd_a;
                r_alu_b      <= cmd_b;
                r_alu_code   <= cmd_code;
                r_settle_cnt <= 4'(SETTLE_CYCLES);
            end else begin
                r_res_c        <= '0;
                r_res_overflow <= 1'b0;
                r_res_err      <= 1'b1;
            end
        end else if (r_state == WAIT) begin
            if (r_settle_cnt != 4'd0) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end else begin
                r_res_c        <= alu_c;
                r_res_overflow <= alu_overflow;
                r_res_err      <= 1'b0;
                r_acc          <= alu_c;
            end
        end
    end

    // Clear takes priority over a coincident overflow capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf_count <= '0;
        else if (stat_clr)
            r_ovf_count <= '0;
        else if (w_capture && alu_overflow && !(&r_ovf_count))
            r_ovf_count <= r_ovf_count + 1'b1;
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_code     = r_alu_code;
    assign res_c        = r_res_c;
    assign res_overflow = r_res_overflow;
    assign res_err      = r_res_err;
    assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer with alu_module
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 16;
    localparam int CODE_W = 5;
    localparam int OVF_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_a = '0;
    logic [WIDTH-1:0]  cmd_b = '0;
    logic [CODE_W-1:0] cmd_code = '0;
    logic              cmd_use_prev = 1'b0;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_c;
    logic [CODE_W-1:0] alu_code;
    logic              alu_overflow;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [WIDTH-1:0]  res_c;
    logic              res_overflow, res_err;
    logic              stat_clr = 1'b0;
    logic [OVF_W-1:0]  ovf_count;

    int n_checks = 0;
    int n_fails = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .WIDTH(WIDTH), .CODE_W(CODE_W), .SETTLE_CYCLES(2), .OVF_CNT_W(OVF_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_code(cmd_code), .cmd_use_prev(cmd_use_prev),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
        .alu_c(alu_c), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_c(res_c), .res_overflow(res_overflow), .res_err(res_err),
        .stat_clr(stat_clr), .ovf_count(ovf_count)
    );

    alu_module u_alu (
        .a(alu_a), .b(alu_b), .alu_code(alu_code), .c(alu_c), .overflow(alu_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [4:0] code,
                         input logic up, output int lat, output logic [15:0] a_seen);
        int guard;
        cmd_a = a; cmd_b = b; cmd_code = code; cmd_use_prev = up; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin tick(); guard++; end
        if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        a_seen = alu_a;
        lat = 1;
        while (!res_valid && lat < 50) begin tick(); lat++; end
        if (!res_valid) check("result_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic take();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] a_seen;
        bit seen_valid;

        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_c", 32'(res_c), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_code", 32'(alu_code), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: signed add overflow
        issue(16'h7FFF, 16'h0001, 5'b00000, 1'b0, lat, a_seen);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_res_c", 32'(res_c), 32'h8000);
        check("t1_res_ovf", 32'(res_overflow), 32'd1);
        check("t1_res_err", 32'(res_err), 32'd0);
        check("t1_ovf_count", 32'(ovf_count), 32'd1);
        take();

        // 2: chaining 5+3 then acc-2
        issue(16'h0005, 16'h0003, 5'b00000, 1'b0, lat, a_seen);
        check("t2_first_c", 32'(res_c), 32'h0008);
        take();
        issue(16'hFFFF, 16'h0002, 5'b00010, 1'b1, lat, a_seen);
        check("t2_alu_a_acc", 32'(a_seen), 32'h0008);
        check("t2_res_c", 32'(res_c), 32'h0006);
        check("t2_res_ovf", 32'(res_overflow), 32'd0);
        take();

        // 3: illegal opcode
        issue(16'h1234, 16'h5678, 5'b00110, 1'b0, lat, a_seen);
        check("t3_latency", 32'(lat), 32'd1);
        check("t3_res_err", 32'(res_err), 32'd1);
        check("t3_res_c", 32'(res_c), 32'd0);
        check("t3_alu_code_kept", 32'(alu_code), 32'b00010);
        check("t3_alu_a_kept", 32'(alu_a), 32'h0008);
        take();
        issue(16'h1234, 16'h0001, 5'b00000, 1'b1, lat, a_seen);
        check("t3_acc_kept_a", 32'(a_seen), 32'h0006);
        check("t3_acc_kept_c", 32'(res_c), 32'h0007);
        check("t3_err_cleared", 32'(res_err), 32'd0);
        take();

        // 4: backpressure
        issue(16'h1111, 16'h2222, 5'b00001, 1'b0, lat, a_seen);
        cmd_a = 16'h00FF; cmd_b = 16'h0F0F; cmd_code = 5'b01010; cmd_use_prev = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_cmd_ready_low", 32'(cmd_ready), 32'd0);
            check("t4_res_c_stable", 32'(res_c), 32'h3333);
            check("t4_res_valid_held", 32'(res_valid), 32'd1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t4_idle_after_hs", 32'(cmd_ready), 32'd1);
        check("t4_not_yet_taken", 32'(alu_a), 32'h1111);
        tick();
        cmd_valid = 1'b0;
        check("t4_accepted_a", 32'(alu_a), 32'h00FF);
        check("t4_busy", 32'(cmd_ready), 32'd0);
        lat = 1;
        while (!res_valid && lat < 50) begin tick(); lat++; end
        check("t4_xor_c", 32'(res_c), 32'h0FF0);
        take();

        // 5: saturation and clear
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("t5_cleared", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 256; i++) begin
            issue(16'h7FFF, 16'h0001, 5'b00000, 1'b0, lat, a_seen);
            if (i == 253) check("t5_count_254", 32'(ovf_count), 32'hFE);
            if (i == 254) check("t5_count_255", 32'(ovf_count), 32'hFF);
            take();
        end
        check("t5_saturated", 32'(ovf_count), 32'hFF);
        cmd_a = 16'h7FFF; cmd_b = 16'h0001; cmd_code = 5'b00000; cmd_use_prev = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("t5_pre_clear", 32'(ovf_count), 32'hFF);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("t5_capture_valid", 32'(res_valid), 32'd1);
        check("t5_capture_ovf", 32'(res_overflow), 32'd1);
        check("t5_clear_wins", 32'(ovf_count), 32'd0);
        take();
        issue(16'h7FFF, 16'h0001, 5'b00000, 1'b0, lat, a_seen);
        check("t5_recount", 32'(ovf_count), 32'd1);
        take();

        // 6: asynchronous reset during WAIT
        cmd_a = 16'h4321; cmd_b = 16'h1111; cmd_code = 5'b00001; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t6_in_wait", 32'(cmd_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t6_res_valid", 32'(res_valid), 32'd0);
        check("t6_alu_a", 32'(alu_a), 32'd0);
        check("t6_alu_b", 32'(alu_b), 32'd0);
        check("t6_alu_code", 32'(alu_code), 32'd0);
        check("t6_ovf_count", 32'(ovf_count), 32'd0);
        tick();
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) seen_valid = 1'b1;
        end
        check("t6_no_result", 32'(seen_valid), 32'd0);
        check("t6_idle", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
